// File: rtl/aes_pkg.sv
// Shared AES definitions: cipher direction, GF(2^8) helpers and the
// column-serial MixColumns FSM encoding.
package aes_pkg;

  typedef enum logic [1:0] {
    CIPH_FWD = 2'b01,
    CIPH_INV = 2'b10
  } ciph_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } aes_mix_cols_iter_e;

  localparam int unsigned AES_MIX_COLS_CNT_W = 2;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] aes_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] aes_mul4(input logic [7:0] b);
    return aes_mul2(aes_mul2(b));
  endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// One-column MixColumns/InvMixColumns. The inverse is the forward matrix
// applied after a {5,0,4,0} circulant pre-multiply, so both share one mixer.
module aes_mix_single_column
  import aes_pkg::*;
(
  input  logic        i_inv,
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [3:0][7:0] w_a;
  logic [3:0][7:0] w_p;
  logic [3:0][7:0] w_b;
  logic [7:0]      w_u;
  logic [7:0]      w_v;

  always_comb begin
    w_a = i_col;
    w_u = aes_mul4(w_a[0] ^ w_a[2]);
    w_v = aes_mul4(w_a[1] ^ w_a[3]);
    w_p = w_a;
    if (i_inv) begin
      w_p[0] = w_a[0] ^ w_u;
      w_p[1] = w_a[1] ^ w_v;
      w_p[2] = w_a[2] ^ w_u;
      w_p[3] = w_a[3] ^ w_v;
    end
    // [2 3 1 1] circulant
    w_b[0] = aes_mul2(w_p[0]) ^ aes_mul2(w_p[1]) ^ w_p[1] ^ w_p[2] ^ w_p[3];
    w_b[1] = aes_mul2(w_p[1]) ^ aes_mul2(w_p[2]) ^ w_p[2] ^ w_p[3] ^ w_p[0];
    w_b[2] = aes_mul2(w_p[2]) ^ aes_mul2(w_p[3]) ^ w_p[3] ^ w_p[0] ^ w_p[1];
    w_b[3] = aes_mul2(w_p[3]) ^ aes_mul2(w_p[0]) ^ w_p[0] ^ w_p[1] ^ w_p[2];
    o_col  = w_b;
  end

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Column-serial MixColumns/InvMixColumns over the 128-bit AES state.
// Define AES_MIX_COLUMNS_ITER_WIPE_EN to zero state and data_o outside DONE.
module aes_mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   op_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o
);

  aes_mix_cols_iter_e              r_fsm;
  aes_mix_cols_iter_e              w_fsm_nxt;
  logic [127:0]                    r_data;
  logic                            r_inv;
  logic [AES_MIX_COLS_CNT_W-1:0]   r_cnt;
  logic                            r_in_ready;

  logic                            w_load;
  logic                            w_busy;
  logic                            w_out_hs;
  logic                            w_in_ready_nxt;
  logic [3:0]                      w_col_we;
  logic [31:0]                     w_col_in;
  logic [31:0]                     w_col_out;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  // Next-state logic
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (in_valid_i) w_fsm_nxt = BUSY;
      BUSY:    if (r_cnt == AES_MIX_COLS_CNT_W'(3)) w_fsm_nxt = DONE;
      DONE:    if (out_ready_i) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    w_load         = 1'b0;
    w_busy         = 1'b0;
    w_out_hs       = 1'b0;
    w_col_we       = 4'b0000;
    w_in_ready_nxt = (w_fsm_nxt == IDLE);
    case (r_fsm)
      IDLE: w_load   = in_valid_i & r_in_ready;
      BUSY: begin
        w_busy = 1'b1;
        case (r_cnt)
          2'd0:    w_col_we = 4'b0001;
          2'd1:    w_col_we = 4'b0010;
          2'd2:    w_col_we = 4'b0100;
          default: w_col_we = 4'b1000;
        endcase
      end
      DONE: w_out_hs = out_ready_i;
      default: ;
    endcase
  end

  // Column select feeding the shared column unit
  always_comb begin
    case (r_cnt)
      2'd0:    w_col_in = r_data[31:0];
      2'd1:    w_col_in = r_data[63:32];
      2'd2:    w_col_in = r_data[95:64];
      default: w_col_in = r_data[127:96];
    endcase
  end

  aes_mix_single_column u_col (
    .i_inv (r_inv),
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  // Datapath: load, per-column write-back, counter and ready register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data     <= '0;
      r_inv      <= 1'b0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      if (w_load) begin
        r_data <= data_i;
        r_inv  <= (op_i == CIPH_INV);
        r_cnt  <= '0;
      end else if (w_busy) begin
        r_cnt <= AES_MIX_COLS_CNT_W'(r_cnt + 1'b1);
        for (int c = 0; c < 4; c++) begin
          if (w_col_we[c]) r_data[32*c +: 32] <= w_col_out;
        end
`ifdef AES_MIX_COLUMNS_ITER_WIPE_EN
      end else if (w_out_hs) begin
        r_data <= '0;
`endif
      end
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = (r_fsm == DONE);

`ifdef AES_MIX_COLUMNS_ITER_WIPE_EN
  assign data_o = out_valid_o ? r_data : '0;
`else
  assign data_o = r_data;
  logic w_unused;
  assign w_unused = w_out_hs;
`endif

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Randomised bench for aes_mix_columns_iter against a GF(2^8) matrix model.
module tb_aes_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [1:0]   op_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] data_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_mix_columns_iter dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .op_i        (op_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Shift-and-add GF(2^8) multiply, reduction by 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix times each column
  function automatic logic [127:0] model(input logic [1:0] op, input logic [127:0] d);
    logic [7:0]   cf[4];
    logic [127:0] res;
    logic [7:0]   acc;
    if (op == 2'b10) cf = '{8'd14, 8'd11, 8'd13, 8'd9};
    else             cf = '{8'd2, 8'd3, 8'd1, 8'd1};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(cf[(k - r + 4) % 4], d[32*c + 8*k +: 8]);
        res[32*c + 8*r +: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic scramble();
    in_valid_i = 1'($urandom);
    op_i       = 2'($urandom);
    data_i     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input string tag, input logic [1:0] op, input logic [127:0] d,
                           input logic [127:0] exp, input int hold);
    int lat;
    int w;
    w = 0;
    while (!in_ready_o && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_acc_rdy"}, 128'(in_ready_o), 128'd1);
    in_valid_i = 1'b1;
    op_i       = op;
    data_i     = d;
    tick();
    lat = 1;
    scramble();
    while (!out_valid_o && lat < 20) begin
      chk({tag, "_busy_rdy"}, 128'(in_ready_o), 128'd0);
      tick();
      lat++;
      scramble();
    end
    chk({tag, "_latency"}, 128'(lat), 128'd5);
    chk({tag, "_data"}, data_o, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      scramble();
      chk({tag, "_hold_vld"}, 128'(out_valid_o), 128'd1);
      chk({tag, "_hold_rdy"}, 128'(in_ready_o), 128'd0);
      chk({tag, "_hold_data"}, data_o, exp);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk({tag, "_post_vld"}, 128'(out_valid_o), 128'd0);
    chk({tag, "_post_rdy"}, 128'(in_ready_o), 128'd1);
`ifdef AES_MIX_COLUMNS_ITER_WIPE_EN
    chk({tag, "_post_wipe"}, data_o, 128'd0);
`else
    chk({tag, "_post_keep"}, data_o, exp);
`endif
  endtask

  initial begin
    logic [1:0]   op;
    logic [127:0] d;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    op_i        = 2'b00;
    data_i      = '0;
    repeat (3) tick();
    chk("rst_rdy", 128'(in_ready_o), 128'd0);
    chk("rst_vld", 128'(out_valid_o), 128'd0);
    chk("rst_data", data_o, 128'd0);
    rst_i = 1'b0;
    tick();
    chk("idle_rdy", 128'(in_ready_o), 128'd1);
    chk("idle_vld", 128'(out_valid_o), 128'd0);

    run_block("fips_fwd", 2'b01, {4{32'h455313db}}, {4{32'hbca14d8e}}, 2);
    run_block("fips_inv", 2'b10, {4{32'hbca14d8e}}, {4{32'h455313db}}, 1);
    run_block("mixed", 2'b01,
              {32'h00000000, 32'h455313db, 32'hc6c6c6c6, 32'h01010101},
              {32'h00000000, 32'hbca14d8e, 32'hc6c6c6c6, 32'h01010101}, 0);
    d = {$urandom, $urandom, $urandom, $urandom};
    run_block("backpr", 2'b10, d, model(2'b10, d), 10);

    // Reset two cycles into a block: it must be dropped
    in_valid_i = 1'b1;
    op_i       = 2'b01;
    data_i     = {4{32'h455313db}};
    tick();
    scramble();
    tick();
    rst_i = 1'b1;
    #1;
    chk("mid_rst_vld", 128'(out_valid_o), 128'd0);
    chk("mid_rst_data", data_o, 128'd0);
    chk("mid_rst_rdy", 128'(in_ready_o), 128'd0);
    in_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    chk("after_rst_rdy", 128'(in_ready_o), 128'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_emit", 128'(out_valid_o), 128'd0);
    end
    run_block("after_rst", 2'b01, {4{32'h455313db}}, {4{32'hbca14d8e}}, 0);

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      d  = {$urandom, $urandom, $urandom, $urandom};
      run_block("rand", op, d, model(op, d), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_mix_columns_iter.md
# aes_mix_columns_iter

Column-serial MixColumns/InvMixColumns engine for the full 128-bit AES state. Accepts a state word over a valid/ready handshake and transforms one 32-bit column per cycle through a single shared column unit. Returns the result over a second valid/ready handshake. It sits between SubBytes/ShiftRows and AddRoundKey in area-optimised round datapaths, where four parallel column units cost too much.

## Interface
Parameters:
- none

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `op_i`  in  2  direction, sampled on the input handshake:
  - `2'b01`: forward MixColumns.
  - `2'b10`: InvMixColumns.
  - Any other value: forward.
- `in_valid_i`  in  1  `data_i` and `op_i` are valid.
- `in_ready_o`  out  1  block can accept; reset 0, then 1 in IDLE.
- `data_i`  in  128  input state.
  - Column c is `data_i[32c +: 32]`.
  - Row r of each column is bits `[8r +: 8]` of that column.
- `out_valid_o`  out  1  `data_o` holds a complete result; reset 0.
- `out_ready_i`  in  1  sink accepts the result.
- `data_o`  out  128  result state, same layout as `data_i`; reset 0.

## Operation
- Arithmetic:
  - GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
  - Forward column matrix: [2 3 1 1] circulant.
  - Inverse column matrix: [14 11 13 9] circulant.
  - All values are 8-bit byte-wise; there is no carry.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready_o`=1, `out_valid_o`=0.
  - On `in_valid_i & in_ready_o`: load `data_i` into the state register, latch `op_i`, clear the 2-bit column counter to 0, go to BUSY.
- BUSY:
  - `in_ready_o`=0.
  - Each cycle, column[cnt] passes through the column unit with the latched op, the result is written back to column[cnt], and cnt increments.
  - When cnt=3 is written, cnt wraps to 0 and the FSM goes to DONE.
- DONE:
  - `out_valid_o`=1 and `data_o` equals the state register; both stay stable until `out_ready_i`.
  - On `out_valid_o & out_ready_i`, go to IDLE.
- Inputs are ignored outside IDLE:
  - `in_valid_i` is ignored.
  - `op_i` and `data_i` changes after acceptance have no effect.
- `out_ready_i` is ignored outside DONE.
- Reset mid-operation (any state):
  - Return to IDLE immediately.
  - Clear the state register, the latched op and the counter.
  - The in-flight block is discarded and never emitted.

## Timing
- Input handshake in cycle T.
- Columns 0..3 are processed in cycles T+1..T+4.
- `out_valid_o` rises in cycle T+5.
- Output handshake in cycle D: `in_ready_o` is high in cycle D+1. IDLE never accepts in the same cycle as the output handshake.
- Peak throughput: one block per 6 cycles (when `out_ready_i` is held high).
- All outputs are registered or decoded from the FSM state; there is no combinational path from any input to any output.

## Configuration
- Macro: `AES_MIX_COLUMNS_ITER_WIPE_EN`.
- Defined:
  - The state register is cleared to zero in the cycle after the output handshake.
  - `data_o` is forced to 0 whenever `out_valid_o`=0.
  - Purpose: no residual state data for side-channel hygiene.
- Undefined:
  - The state register retains its last value.
  - `data_o` always reflects the state register.
  - Handshake timing is identical in both builds.

## Structure
- Shared package `aes_pkg` holds:
  - Direction encoding `ciph_op_e` (`CIPH_FWD`=`2'b01`, `CIPH_INV`=`2'b10`).
  - GF helpers `aes_mul2` and `aes_mul4`.
  - New typedef `aes_mix_cols_iter_e` {IDLE, BUSY, DONE}.
  - New localparam `AES_MIX_COLS_CNT_W`=2.
- One sub-module: a single `aes_mix_single_column` instance.
  - Its input is a 4:1 column mux driven by cnt.
  - Its output is written back through per-column enables.

## Test plan
- Forward FIPS-197 column:
  - Stimulus: op=`01`, every column=`32'h455313db`.
  - Response: after 5 cycles, every column=`32'hbca14d8e`.
- Inverse column:
  - Stimulus: op=`10`, every column=`32'hbca14d8e`.
  - Response: every column=`32'h455313db`.
- Mixed state:
  - Stimulus: columns {`32'h01010101`, `32'hc6c6c6c6`, `32'h455313db`, `32'h00000000`}, forward.
  - Response: {`32'h01010101`, `32'hc6c6c6c6`, `32'hbca14d8e`, `32'h00000000`}.
- Backpressure:
  - Stimulus: hold `out_ready_i`=0 for 10 cycles; toggle `in_valid_i` and `data_i` meanwhile.
  - Response: `data_o` stable, `in_ready_o`=0, no second accept, handshake timing as specified.
- Reset mid-BUSY:
  - Stimulus: assert `rst_i` at T+2.
  - Response: `out_valid_o`=0, `data_o`=0, `in_ready_o`=1 after release, the next block is processed correctly.
- Wipe build (`AES_MIX_COLUMNS_ITER_WIPE_EN` defined):
  - Stimulus: complete one block.
  - Response: `data_o`=0 in the cycle after the output handshake.
